prbs_check: RTL and testbench

- Receive-side checker for the 31-bit PRBS word stream used by the Monte Carlo datapath. It sits downstream of the random source, or on a link that carries its words.
- Self-synchronises a local PRBS31 LFSR to the incoming words, declares lock, then counts received words and word errors.
- Gives bring-up and regression a hardware check that the random stream feeding the pi estimator is intact.

---
 rtl/prbs_check.sv | 153 +++++++++++++++
 tb/tb_prbs_check.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_check.sv
// PRBS31 receive checker: self-synchronises a local LFSR to incoming words,
// declares lock, then counts received words and word errors.
module prbs_check #(
    parameter int unsigned STEP       = 31,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 8,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [30:0]      data_in,
    input  logic             valid_in,
    output logic             locked,
    output logic             err_pulse,
    output logic             sticky_err,
    output logic [CNT_W-1:0] word_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned W     = 31;
    localparam int unsigned RUN_W = 4;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [W-1:0]       exp_word, exp_word_d;
    logic [RUN_W-1:0]   match_cnt, match_cnt_d;
    logic [RUN_W-1:0]   miss_cnt, miss_cnt_d;
    logic               locked_d, err_pulse_d, sticky_err_d;
    logic [CNT_W-1:0]   word_count_d, err_count_d;
    logic [W-1:0]       adv_data, adv_exp;
    logic [RUN_W-1:0]   match_inc, miss_inc;

    // Single LFSR shift: feedback from taps 31 and 28.
    function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s);
        return {s[W-2:0], s[30] ^ s[27]};
    endfunction

    // Advance a word by STEP shifts to predict the next valid word.
    function automatic logic [W-1:0] advance(input logic [W-1:0] s);
        logic [W-1:0] r;
        r = s;
        for (int unsigned i = 0; i < STEP; i++) begin
            r = lfsr_step(r);
        end
        return r;
    endfunction

    assign adv_data  = advance(data_in);
    assign adv_exp   = advance(exp_word);
    assign match_inc = match_cnt + RUN_W'(1);
    assign miss_inc  = miss_cnt + RUN_W'(1);

    // Next-state and output decode.
    always_comb begin
        state_d      = state;
        exp_word_d   = exp_word;
        match_cnt_d  = match_cnt;
        miss_cnt_d   = miss_cnt;
        locked_d     = locked;
        err_pulse_d  = 1'b0;
        sticky_err_d = sticky_err;
        word_count_d = word_count;
        err_count_d  = err_count;

        if (valid_in) begin
            case (state)
                HUNT: begin
                    // The all-zero word is not a legal LFSR state, so it cannot seed.
                    if (data_in != '0) begin
                        exp_word_d  = adv_data;
                        match_cnt_d = '0;
                        state_d     = VERIFY;
                    end
                end
                VERIFY: begin
                    if (data_in == exp_word) begin
                        exp_word_d  = adv_exp;
                        match_cnt_d = match_inc;
                        if (match_inc == RUN_W'(LOCK_COUNT)) begin
                            state_d    = LOCK;
                            locked_d   = 1'b1;
                            miss_cnt_d = '0;
                        end
                    end else begin
                        state_d = HUNT;
                    end
                end
                LOCK: begin
                    exp_word_d = adv_exp;
                    if (word_count != '1) begin
                        word_count_d = word_count + CNT_W'(1);
                    end
                    if (data_in == exp_word) begin
                        miss_cnt_d = '0;
                    end else begin
                        err_pulse_d  = 1'b1;
                        sticky_err_d = 1'b1;
                        miss_cnt_d   = miss_inc;
                        if (err_count != '1) begin
                            err_count_d = err_count + CNT_W'(1);
                        end
                        if (miss_inc == RUN_W'(LOSS_COUNT)) begin
                            state_d  = HUNT;
                            locked_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d  = HUNT;
                    locked_d = 1'b0;
                end
            endcase
        end

        // Clear overrides any count taken on the same edge; err_pulse is unaffected.
        if (clear) begin
            word_count_d = '0;
            err_count_d  = '0;
            sticky_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= HUNT;
            exp_word   <= '0;
            match_cnt  <= '0;
            miss_cnt   <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            sticky_err <= 1'b0;
            word_count <= '0;
            err_count  <= '0;
        end else begin
            state      <= state_d;
            exp_word   <= exp_word_d;
            match_cnt  <= match_cnt_d;
            miss_cnt   <= miss_cnt_d;
            locked     <= locked_d;
            err_pulse  <= err_pulse_d;
            sticky_err <= sticky_err_d;
            word_count <= word_count_d;
            err_count  <= err_count_d;
        end
    end

endmodule

// File: tb/tb_prbs_check.sv
// Bench for prbs_check: default instance and a narrow-counter instance, checked
// against a bit-stream PRBS31 reference and a rule-level checker model.
module tb_prbs_check;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        clear_a, clear_b, valid_a, valid_b;
    logic [30:0] data_a, data_b;
    logic        locked_a, err_pulse_a, sticky_err_a;
    logic        locked_b, err_pulse_b, sticky_err_b;
    logic [31:0] word_count_a, err_count_a;
    logic [3:0]  word_count_b, err_count_b;

    int n_cmp = 0;
    int n_err = 0;

    prbs_check dut_a (
        .clk(clk), .rst(rst_a), .clear(clear_a), .data_in(data_a), .valid_in(valid_a),
        .locked(locked_a), .err_pulse(err_pulse_a), .sticky_err(sticky_err_a),
        .word_count(word_count_a), .err_count(err_count_a)
    );

    prbs_check #(.STEP(31), .LOCK_COUNT(4), .LOSS_COUNT(15), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst_b), .clear(clear_b), .data_in(data_b), .valid_in(valid_b),
        .locked(locked_b), .err_pulse(err_pulse_b), .sticky_err(sticky_err_b),
        .word_count(word_count_b), .err_count(err_count_b)
    );

    always #5 clk = ~clk;

    // Reference model state, one slot per instance (0 = default, 1 = narrow).
    int          m_mode [2];
    logic [30:0] m_exp [2];
    int          m_run [2];
    int          m_miss [2];
    bit          m_locked [2], m_pulse [2], m_sticky [2];
    longint      m_wc [2], m_ec [2];
    longint      m_max [2] = '{64'hFFFF_FFFF, 15};
    int          m_loss [2] = '{8, 15};

    // Next PRBS31 word: the stream obeys b[n] = b[n-31] ^ b[n-28]; a word holds 31 bits, newest in bit 0.
    function automatic logic [30:0] gen(input logic [30:0] w);
        bit          b[$];
        logic [30:0] r;
        for (int i = 30; i >= 0; i--) b.push_back(w[i]);
        repeat (31) b.push_back(b[$-30] ^ b[$-27]);
        for (int i = 0; i < 31; i++) r[i] = b[$-i];
        return r;
    endfunction

    task automatic model_reset(input int k);
        m_mode[k] = 0; m_exp[k] = '0; m_run[k] = 0; m_miss[k] = 0;
        m_locked[k] = 0; m_pulse[k] = 0; m_sticky[k] = 0; m_wc[k] = 0; m_ec[k] = 0;
    endtask

    task automatic model_step(input int k, input logic [30:0] d, input bit v, input bit c);
        m_pulse[k] = 0;
        if (v) begin
            if (m_mode[k] == 0) begin
                if (d != 0) begin
                    m_exp[k] = gen(d); m_run[k] = 0; m_mode[k] = 1;
                end
            end else if (m_mode[k] == 1) begin
                if (d == m_exp[k]) begin
                    m_exp[k] = gen(m_exp[k]);
                    m_run[k]++;
                    if (m_run[k] == 4) begin
                        m_mode[k] = 2; m_locked[k] = 1; m_miss[k] = 0;
                    end
                end else begin
                    m_mode[k] = 0;
                end
            end else begin
                if (m_wc[k] < m_max[k]) m_wc[k]++;
                if (d == m_exp[k]) begin
                    m_miss[k] = 0;
                end else begin
                    m_pulse[k] = 1; m_sticky[k] = 1; m_miss[k]++;
                    if (m_ec[k] < m_max[k]) m_ec[k]++;
                    if (m_miss[k] == m_loss[k]) begin
                        m_mode[k] = 0; m_locked[k] = 0;
                    end
                end
                m_exp[k] = gen(m_exp[k]);
            end
        end
        if (c) begin
            m_wc[k] = 0; m_ec[k] = 0; m_sticky[k] = 0;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs(input int k, input string tag);
        if (k == 0) begin
            check({tag, ".locked"}, 64'(locked_a), 64'(m_locked[0]));
            check({tag, ".err_pulse"}, 64'(err_pulse_a), 64'(m_pulse[0]));
            check({tag, ".sticky_err"}, 64'(sticky_err_a), 64'(m_sticky[0]));
            check({tag, ".word_count"}, 64'(word_count_a), 64'(m_wc[0]));
            check({tag, ".err_count"}, 64'(err_count_a), 64'(m_ec[0]));
        end else begin
            check({tag, ".locked"}, 64'(locked_b), 64'(m_locked[1]));
            check({tag, ".err_pulse"}, 64'(err_pulse_b), 64'(m_pulse[1]));
            check({tag, ".sticky_err"}, 64'(sticky_err_b), 64'(m_sticky[1]));
            check({tag, ".word_count"}, 64'(word_count_b), 64'(m_wc[1]));
            check({tag, ".err_count"}, 64'(err_count_b), 64'(m_ec[1]));
        end
    endtask

    // One clock of stimulus on instance k, then compare against the model.
    task automatic step(input int k, input logic [30:0] d, input bit v, input bit c, input string tag);
        if (k == 0) begin
            data_a = d; valid_a = v; clear_a = c;
        end else begin
            data_b = d; valid_b = v; clear_b = c;
        end
        @(posedge clk);
        #1;
        model_step(k, d, v, c);
        check_outputs(k, tag);
        if (k == 0) begin
            valid_a = 1'b0; clear_a = 1'b0;
        end else begin
            valid_b = 1'b0; clear_b = 1'b0;
        end
    endtask

    function automatic logic [30:0] flip(input logic [30:0] w);
        logic [30:0] m;
        m = 31'(1) << $urandom_range(0, 30);
        return w ^ m;
    endfunction

    function automatic logic [30:0] rand_seed();
        logic [30:0] s;
        s = 31'($urandom);
        if (s == '0) s = 31'h1234;
        return s;
    endfunction

    initial begin
        logic [30:0] g, w;
        int          first_lock;
        bit          v, c;

        rst_a = 1'b0; rst_b = 1'b0;
        clear_a = 1'b0; clear_b = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
        data_a = '0; data_b = '0;
        model_reset(0); model_reset(1);
        #2;
        check_outputs(0, "reset_a");
        check_outputs(1, "reset_b");
        #10;
        rst_a = 1'b1; rst_b = 1'b1;

        // Seed 1, then 9, then the advanced stream; lock on the 5th word.
        first_lock = 0;
        step(0, 31'h1, 1, 0, "seed1");
        step(0, 31'h9, 1, 0, "seed9");
        g = gen(31'h9);
        if (locked_a && first_lock == 0) first_lock = 2;
        for (int i = 3; i <= 10; i++) begin
            step(0, g, 1, 0, "acquire");
            g = gen(g);
            if (locked_a && first_lock == 0) first_lock = i;
        end
        check("lock_word_index", 64'(first_lock), 64'd5);
        check("words_after_lock", 64'(word_count_a), 64'd5);

        // Single bit-0 error while locked, then a good word.
        step(0, g ^ 31'h1, 1, 0, "bit0_err");
        g = gen(g);
        step(0, g, 0, 0, "idle_after_err");
        step(0, g, 1, 0, "good_after_err");
        g = gen(g);

        // Eight corrupted words drop lock; the clean stream relocks after 5.
        for (int i = 0; i < 8; i++) begin
            step(0, flip(g), 1, 0, "loss_run");
            g = gen(g);
        end
        check("loss_err_count", 64'(err_count_a), 64'd9);
        for (int i = 0; i < 5; i++) begin
            step(0, g, 1, 0, "relock");
            g = gen(g);
        end
        check("relock_locked", 64'(locked_a), 64'd1);

        // Knock into HUNT, then zero words are ignored before a fresh seed.
        for (int i = 0; i < 8; i++) begin
            step(0, flip(g), 1, 0, "to_hunt");
            g = gen(g);
        end
        for (int i = 0; i < 3; i++) step(0, 31'h0, 1, 0, "zero_word");
        g = rand_seed();
        for (int i = 0; i < 6; i++) begin
            step(0, g, 1, 0, "after_zero");
            g = gen(g);
        end

        // Wrong third word during VERIFY returns to HUNT without locking.
        for (int i = 0; i < 8; i++) begin
            step(0, flip(g), 1, 0, "to_hunt2");
            g = gen(g);
        end
        step(0, '0, 0, 1, "clear_idle");
        g = rand_seed();
        step(0, g, 1, 0, "vfy_seed");
        g = gen(g);
        step(0, g, 1, 0, "vfy_good");
        g = gen(g);
        step(0, flip(g), 1, 0, "vfy_bad");
        step(0, '0, 0, 0, "vfy_idle");
        check("vfy_word_count", 64'(word_count_a), 64'd0);

        // Randomized traffic: gaps, injected errors, clears, stream reseeds.
        g = rand_seed();
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 99) < 80);
            c = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 79) == 0) g = rand_seed();
            if (v) begin
                w = ($urandom_range(0, 9) == 0) ? flip(g) : g;
                g = gen(g);
            end else begin
                w = 31'($urandom);
            end
            step(0, w, v, c, "random");
        end

        // Narrow counters: lock, then mostly-errored stream saturates both counts.
        g = rand_seed();
        for (int i = 0; i < 5; i++) begin
            step(1, g, 1, 0, "b_lock");
            g = gen(g);
        end
        for (int i = 0; i < 25; i++) begin
            step(1, (i % 5 == 4) ? g : flip(g), 1, 0, "b_sat");
            g = gen(g);
        end
        check("b_err_sat", 64'(err_count_b), 64'd15);
        check("b_word_sat", 64'(word_count_b), 64'd15);
        step(1, flip(g), 1, 1, "b_clear_err");
        g = gen(g);
        check("b_clear_pulse", 64'(err_pulse_b), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step(1, g, 1, 0, "b_post_clear");
            g = gen(g);
        end

        // Asynchronous reset mid-stream, away from any clock edge.
        #3;
        rst_b = 1'b0;
        #1;
        model_reset(1);
        check_outputs(1, "b_async_rst");
        #2;
        rst_b = 1'b1;
        step(1, g, 1, 0, "b_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
